// File: rtl/demux_1_4_2_bit_reg.sv
// Registered 1-to-4 code demultiplexer: each output slot is a one-entry valid/ready buffer.
// Optional discard counter on o_err_cnt is built only when DEMUX_ERR_CNT_EN is defined.
module demux_1_4_2_bit_reg #(
  parameter int DATA_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_code,
  input  logic [1:0]        i_sel_code,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_code_0,
  output logic [DATA_W-1:0] o_code_1,
  output logic [DATA_W-1:0] o_code_2,
  output logic [DATA_W-1:0] o_code_3,
  output logic [3:0]        o_valid,
  input  logic [3:0]        i_ready,
  output logic [CNT_W-1:0]  o_err_cnt
);

  logic [3:0]        valid_q;
  logic [3:0]        valid_d;
  logic [DATA_W-1:0] code_q [4];
  logic [DATA_W-1:0] code_d [4];
  logic              accept;
  logic [3:0]        load_oh;
  logic [3:0]        drain;

  // A full destination slot still accepts when it is being drained in the same cycle,
  // which keeps one transfer per cycle flowing. Gated by reset so o_ready is 0 while held.
  assign o_ready = i_rst_n & i_en &
                   (~valid_q[i_sel_code] | i_ready[i_sel_code]);
  assign accept  = i_valid & o_ready;

  always_comb begin
    load_oh = 4'b0000;
    if (accept) begin
      load_oh[i_sel_code] = 1'b1;
    end
    drain   = valid_q & i_ready;
    valid_d = (valid_q & ~drain) | load_oh;
    for (int k = 0; k < 4; k++) begin
      code_d[k] = load_oh[k] ? i_code : code_q[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        code_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < 4; k++) begin
        code_q[k] <= code_d[k];
      end
    end
  end

  assign o_valid  = valid_q;
  assign o_code_0 = code_q[0];
  assign o_code_1 = code_q[1];
  assign o_code_2 = code_q[2];
  assign o_code_3 = code_q[3];

`ifdef DEMUX_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] err_cnt_d;
  logic             discard;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  assign discard = i_valid & ~i_en;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (discard) begin
      err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_err_cnt = err_cnt_q;
`else
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_1_4_2_bit_reg.sv
// Scoreboard bench for demux_1_4_2_bit_reg: accepted codes are queued per slot and
// a monitor compares every drained slot against its queue.
module tb_demux_1_4_2_bit_reg;

  localparam int DATA_W = 2;
  localparam int CNT_W  = 2;

  logic              i_clk;
  logic              i_rst_n;
  logic              i_en;
  logic              i_valid;
  logic [DATA_W-1:0] i_code;
  logic [1:0]        i_sel_code;
  logic              o_ready;
  logic [DATA_W-1:0] o_code_0;
  logic [DATA_W-1:0] o_code_1;
  logic [DATA_W-1:0] o_code_2;
  logic [DATA_W-1:0] o_code_3;
  logic [3:0]        o_valid;
  logic [3:0]        i_ready;
  logic [CNT_W-1:0]  o_err_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] exp_q [4][$];
  int err_exp3;

  demux_1_4_2_bit_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_valid    (i_valid),
    .i_code     (i_code),
    .i_sel_code (i_sel_code),
    .o_ready    (o_ready),
    .o_code_0   (o_code_0),
    .o_code_1   (o_code_1),
    .o_code_2   (o_code_2),
    .o_code_3   (o_code_3),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_err_cnt  (o_err_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] slot_code(input int k);
    case (k)
      0:       return o_code_0;
      1:       return o_code_1;
      2:       return o_code_2;
      default: return o_code_3;
    endcase
  endfunction

  // Monitor: every drain handshake pops the oldest expected code for that slot.
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst_n) begin
        for (int k = 0; k < 4; k++) begin
          if (o_valid[k] && i_ready[k]) begin
            if (exp_q[k].size() == 0) begin
              chk($sformatf("drain_unexpected_slot%0d", k), 32'd1, 32'd0);
            end else begin
              chk($sformatf("drain_code_slot%0d", k), 32'(slot_code(k)),
                  32'(exp_q[k].pop_front()));
            end
          end
        end
      end
    end
  end

  task automatic drive(input logic en, input logic v, input logic [1:0] sel,
                       input logic [1:0] code, input logic [3:0] rdy);
    i_en       = en;
    i_valid    = v;
    i_sel_code = sel;
    i_code     = code;
    i_ready    = rdy;
  endtask

  // One cycle: check o_ready against the hand value at the negedge, record accepts.
  task automatic step(input string nm, input logic exp_rdy);
    @(negedge i_clk);
    chk(nm, 32'(o_ready), 32'(exp_rdy));
    if (i_valid && exp_rdy) exp_q[i_sel_code].push_back(i_code);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef DEMUX_ERR_CNT_EN
    err_exp3 = 3;
`else
    err_exp3 = 0;
`endif
    // Reset state with input pending
    i_rst_n = 1'b0;
    drive(1'b1, 1'b1, 2'd0, 2'd3, 4'b0000);
    #2;
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_ready", 32'(o_ready), 32'h0);
    chk("rst_code0", 32'(o_code_0), 32'h0);
    chk("rst_err",   32'(o_err_cnt), 32'h0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // Steering to all four slots, then a blocked fifth input
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 2'(k), 2'(k), 4'b0000);
      step($sformatf("steer_ready%0d", k), 1'b1);
    end
    chk("steer_valid", 32'(o_valid), 32'hf);
    for (int k = 0; k < 4; k++) chk($sformatf("steer_code%0d", k), 32'(slot_code(k)), k);
    drive(1'b1, 1'b1, 2'd1, 2'd2, 4'b0000);
    step("steer_full_ready", 1'b0);
    drive(1'b1, 1'b0, 2'd1, 2'd0, 4'b1111);
    step("steer_drain_ready", 1'b1);
    chk("steer_drained", 32'(o_valid), 32'h0);

    // Back-pressure on slot 1
    drive(1'b1, 1'b1, 2'd1, 2'd1, 4'b0000);
    step("bp_load", 1'b1);
    drive(1'b1, 1'b1, 2'd1, 2'd2, 4'b0000);
    step("bp_stall0", 1'b0);
    step("bp_stall1", 1'b0);
    chk("bp_hold_code", 32'(o_code_1), 32'h1);
    drive(1'b1, 1'b1, 2'd1, 2'd2, 4'b0010);
    step("bp_release", 1'b1);
    chk("bp_new_code",  32'(o_code_1), 32'h2);
    chk("bp_new_valid", 32'(o_valid), 32'h2);
    drive(1'b1, 1'b0, 2'd1, 2'd0, 4'b0010);
    step("bp_drain", 1'b1);

    // Streaming into slot 3 with the consumer always ready
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 1'b1, 2'd3, 2'(c), 4'b1000);
      step($sformatf("stream_ready%0d", c), 1'b1);
      chk($sformatf("stream_code%0d", c), 32'(o_code_3), c);
      chk($sformatf("stream_valid%0d", c), 32'(o_valid), 32'h8);
    end
    drive(1'b1, 1'b0, 2'd3, 2'd0, 4'b1000);
    step("stream_tail", 1'b1);
    chk("stream_empty", 32'(o_valid), 32'h0);

    // Disable: slot 0 full, three discarded inputs, then drain
    drive(1'b1, 1'b1, 2'd0, 2'd2, 4'b0000);
    step("dis_load", 1'b1);
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, 2'd2, 2'd3, 4'b0000);
      step($sformatf("dis_ready%0d", c), 1'b0);
    end
    chk("dis_valid", 32'(o_valid), 32'h1);
    drive(1'b0, 1'b0, 2'd0, 2'd0, 4'b0001);
    step("dis_drain", 1'b0);
    chk("dis_drained", 32'(o_valid), 32'h0);
    chk("dis_code0_kept", 32'(o_code_0), 32'h2);
    chk("dis_code2_kept", 32'(o_code_2), 32'h2);
    chk("dis_err", 32'(o_err_cnt), err_exp3);

    // Asynchronous reset mid-cycle with slot 2 full
    drive(1'b1, 1'b1, 2'd2, 2'd1, 4'b0000);
    step("ar_load", 1'b1);
    chk("ar_pre_valid", 32'(o_valid), 32'h4);
    drive(1'b1, 1'b1, 2'd0, 2'd3, 4'b0000);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(o_valid), 32'h0);
    chk("ar_code2", 32'(o_code_2), 32'h0);
    chk("ar_ready", 32'(o_ready), 32'h0);
    chk("ar_err",   32'(o_err_cnt), 32'h0);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // Saturation of the discard counter
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b1, 2'd1, 2'd1, 4'b0000);
      step($sformatf("sat_ready%0d", c), 1'b0);
      if (c == 2) chk("sat_err3", 32'(o_err_cnt), err_exp3);
    end
    chk("sat_err5", 32'(o_err_cnt), err_exp3);
    chk("sat_no_load", 32'(o_valid), 32'h0);
    drive(1'b0, 1'b0, 2'd0, 2'd0, 4'b0000);
    step("sat_idle", 1'b0);
    chk("sat_hold", 32'(o_err_cnt), err_exp3);

    for (int k = 0; k < 4; k++) chk($sformatf("sb_left_slot%0d", k), exp_q[k].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
